// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sequential multiplier
package mult_pkg;

  // Default operand width; the product is twice this wide.
  localparam int MULT_WIDTH = 32;

  // Controller states: waiting for a request, iterating, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_step.sv
// rtl/mult_step.sv - one combinational shift-add multiply iteration
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0]   o_mplier
);

  // Upper half plus an explicit carry bit so no add overflow is lost.
  logic [WIDTH:0] w_sum;
  logic           w_unused_acc_lsb;

  assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
               + (i_mplier[0] ? {1'b0, i_mcand} : {(WIDTH+1){1'b0}});

  // {carry, sum, lower} shifted right by one; the old LSB falls off.
  assign o_acc            = {w_sum, i_acc[WIDTH-1:1]};
  assign o_mplier         = {1'b0, i_mplier[WIDTH-1:1]};
  assign w_unused_acc_lsb = i_acc[0];

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequential shift-add HI/LO multiplier (option: MULT_SEQ_SIGNED_EN)
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mult_state_t        r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_mplier_next;
  logic [2*WIDTH-1:0] w_result;
  logic [WIDTH-1:0]   w_a_load;
  logic [WIDTH-1:0]   w_b_load;

`ifdef MULT_SEQ_SIGNED_EN
  // Set when exactly one signed operand is negative; product is negated at the end.
  logic r_neg;
  logic w_neg_load;

  // Signed requests iterate on magnitudes; the most negative value maps to itself,
  // which is its correct unsigned magnitude.
  assign w_a_load   = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_b_load   = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign w_neg_load = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign w_result   = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
`else
  // Unsigned-only build: the sign request is accepted on the port but has no effect.
  logic w_unused_sgn;

  assign w_a_load     = a;
  assign w_b_load     = b;
  assign w_result     = w_acc_next;
  assign w_unused_sgn = sgn;
`endif

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .o_acc    (w_acc_next),
    .o_mplier (w_mplier_next)
  );

  // Controller and datapath: accept in IDLE, WIDTH iterations in BUSY, pulse in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      r_neg    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= w_a_load;
            r_mplier <= w_b_load;
`ifdef MULT_SEQ_SIGNED_EN
            r_neg    <= w_neg_load;
`endif
            r_acc    <= '0;
            r_cnt    <= CNT_LOAD;
            r_busy   <= 1'b1;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_acc    <= w_acc_next;
          r_mplier <= w_mplier_next;
          r_cnt    <= r_cnt - CNT_ONE;
          // Last iteration: its result goes straight into HI/LO.
          if (r_cnt == CNT_ONE) begin
            r_hi    <= w_result[2*WIDTH-1:WIDTH];
            r_lo    <= w_result[WIDTH-1:0];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // A start seen here is dropped; the next accept is in IDLE.
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Hold the pipeline during iteration and on the cycle a request is accepted.
  assign stall = r_busy | (start & (r_state == IDLE));
  assign busy  = r_busy;
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule
